// File: rtl/digitron_scan_display.sv
// ============================================================================
// Module      : digitron_scan_display
// Description : Multiplexed common-anode seven-segment scanner with per-frame
//               data snapshot, decimal points, PWM brightness and optional
//               leading-zero blanking (enabled by defining DIGI_SCAN_LZB_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digitron_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 262144,
    parameter int BRIGHT_W = 4
) (
    input  logic                  Digi_Scan_clk,
    input  logic                  Digi_Scan_reset,
    input  logic [4*DIGITS-1:0]   Digi_Scan_data,
    input  logic [DIGITS-1:0]     Digi_Scan_dp,
    input  logic                  Digi_Scan_blank_en,
    input  logic [BRIGHT_W-1:0]   Digi_Scan_bright,
    output logic [DIGITS-1:0]     Digi_Scan_AN,
    output logic [7:0]            Digi_Scan_seg,
    output logic                  Digi_Scan_frame_done
);

    localparam int c_presc_w = $clog2(SCAN_DIV);
    localparam int c_idx_w   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_presc_w-1:0] c_presc_tc  = c_presc_w'(SCAN_DIV - 1);
    localparam logic [c_presc_w-1:0] c_presc_one = c_presc_w'(1);
    localparam logic [c_idx_w-1:0]   c_idx_last  = c_idx_w'(DIGITS - 1);
    localparam logic [c_idx_w-1:0]   c_idx_one   = c_idx_w'(1);

    logic [c_presc_w-1:0] presc_q, presc_d;
    logic [c_idx_w-1:0]   idx_q, idx_d;
    logic [BRIGHT_W-1:0]  pwm_q;
    logic [4*DIGITS-1:0]  data_q;
    logic [DIGITS-1:0]    dp_q;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [7:0]           seg_q, seg_d;
    logic                 frame_done_q;

    logic                 w_presc_tc;
    logic                 w_frame_wrap;
    logic                 w_lit;
    logic [3:0]           w_cur_nib;
    logic                 w_cur_dp;
    logic                 w_cur_blank;
    logic [DIGITS-1:0]    w_blank;

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    f_glyph = 7'h40;
            4'h1:    f_glyph = 7'h79;
            4'h2:    f_glyph = 7'h24;
            4'h3:    f_glyph = 7'h30;
            4'h4:    f_glyph = 7'h19;
            4'h5:    f_glyph = 7'h12;
            4'h6:    f_glyph = 7'h02;
            4'h7:    f_glyph = 7'h78;
            4'h8:    f_glyph = 7'h00;
            4'h9:    f_glyph = 7'h10;
            4'hA:    f_glyph = 7'h08;
            4'hB:    f_glyph = 7'h03;
            4'hC:    f_glyph = 7'h46;
            4'hD:    f_glyph = 7'h21;
            4'hE:    f_glyph = 7'h06;
            default: f_glyph = 7'h0E;
        endcase
    endfunction

    assign w_presc_tc   = (presc_q == c_presc_tc);
    assign w_frame_wrap = w_presc_tc && (idx_q == c_idx_last);

    always_comb begin
        presc_d = w_presc_tc ? '0 : presc_q + c_presc_one;
        idx_d   = idx_q;
        if (w_presc_tc) begin
            idx_d = (idx_q == c_idx_last) ? '0 : idx_q + c_idx_one;
        end
    end

`ifdef DIGI_SCAN_LZB_EN
    logic blank_en_q;
    logic w_zero_run;

    // Walk from the most significant digit down; a digit is blank while every
    // nibble from the top down to it is zero. Digit 0 is never blanked.
    always_comb begin
        w_zero_run = blank_en_q;
        w_blank    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run & (data_q[4*i +: 4] == 4'h0);
            w_blank[i] = w_zero_run;
        end
    end

    always_ff @(posedge Digi_Scan_clk) begin
        if (Digi_Scan_reset) begin
            blank_en_q <= 1'b0;
        end else if (w_frame_wrap) begin
            blank_en_q <= Digi_Scan_blank_en;
        end
    end
`else
    logic w_unused_blank_en;
    assign w_unused_blank_en = Digi_Scan_blank_en;
    assign w_blank           = '0;
`endif

    always_comb begin
        w_cur_nib   = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == c_idx_w'(i)) begin
                w_cur_nib   = data_q[4*i +: 4];
                w_cur_dp    = dp_q[i];
                w_cur_blank = w_blank[i];
            end
        end
    end

    // Brightness is applied live; full scale bypasses the compare so the
    // all-ones code really means 100 % duty.
    assign w_lit = (&Digi_Scan_bright) || (pwm_q < Digi_Scan_bright);

    always_comb begin
        an_d  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_lit && (idx_q == c_idx_w'(i))) begin
                an_d[i] = 1'b0;
            end
        end
        seg_d = {~w_cur_dp, (w_cur_blank ? 7'h7F : f_glyph(w_cur_nib))};
    end

    always_ff @(posedge Digi_Scan_clk) begin
        if (Digi_Scan_reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pwm_q        <= '0;
            data_q       <= '0;
            dp_q         <= '0;
            an_q         <= '1;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pwm_q        <= pwm_q + BRIGHT_W'(1);
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= w_frame_wrap;
            if (w_frame_wrap) begin
                data_q <= Digi_Scan_data;
                dp_q   <= Digi_Scan_dp;
            end
        end
    end

    assign Digi_Scan_AN         = an_q;
    assign Digi_Scan_seg        = seg_q;
    assign Digi_Scan_frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_digitron_scan_display.sv
// Bench for digitron_scan_display: a 4-digit instance and a 1-digit instance
// checked cycle by cycle against a count-based model through a queue.
`default_nettype none

module tb_digitron_scan_display;

    localparam int D  = 4;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        ben;
    logic [1:0]  bright;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        fd;

    logic [3:0]  data2 = 4'h7;
    logic        an2;
    logic [7:0]  seg2;
    logic        fd2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    digitron_scan_display #(.DIGITS(D), .SCAN_DIV(SD), .BRIGHT_W(2)) u_dut (
        .Digi_Scan_clk(clk), .Digi_Scan_reset(rst), .Digi_Scan_data(data),
        .Digi_Scan_dp(dp), .Digi_Scan_blank_en(ben), .Digi_Scan_bright(bright),
        .Digi_Scan_AN(an), .Digi_Scan_seg(seg), .Digi_Scan_frame_done(fd)
    );

    digitron_scan_display #(.DIGITS(1), .SCAN_DIV(2), .BRIGHT_W(2)) u_dut1 (
        .Digi_Scan_clk(clk), .Digi_Scan_reset(rst), .Digi_Scan_data(data2),
        .Digi_Scan_dp(1'b0), .Digi_Scan_blank_en(1'b0), .Digi_Scan_bright(2'b11),
        .Digi_Scan_AN(an2), .Digi_Scan_seg(seg2), .Digi_Scan_frame_done(fd2)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
        logic       an2;
        logic [7:0] seg2;
        logic       fd2;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [7:0] t;
        case (n)
            4'h0: t = 8'hC0; 4'h1: t = 8'hF9; 4'h2: t = 8'hA4; 4'h3: t = 8'hB0;
            4'h4: t = 8'h99; 4'h5: t = 8'h92; 4'h6: t = 8'h82; 4'h7: t = 8'hF8;
            4'h8: t = 8'h80; 4'h9: t = 8'h90; 4'hA: t = 8'h88; 4'hB: t = 8'h83;
            4'hC: t = 8'hC6; 4'hD: t = 8'hA1; 4'hE: t = 8'h86; default: t = 8'h8E;
        endcase
        return t[6:0];
    endfunction

    // Model: state after k edges since reset is a pure function of k; outputs
    // after edge k show the state left by edge k-1.
    int          k;
    logic [15:0] sh_data;
    logic [3:0]  sh_dp;
    logic        sh_ben;
    logic [3:0]  sh2;

    always @(posedge clk) begin
        exp_t e;
        int   idx, pwm;
        logic blank;
        if (rst) begin
            k = 0; sh_data = '0; sh_dp = '0; sh_ben = 1'b0; sh2 = '0;
            e = '{an: 4'hF, seg: 8'hFF, fd: 1'b0, an2: 1'b1, seg2: 8'hFF, fd2: 1'b0};
        end else begin
            k++;
            idx = ((k - 1) / SD) % D;
            pwm = (k - 1) % 4;
            e.an = 4'hF;
            if (bright == 2'd3 || pwm < int'(bright)) e.an[idx] = 1'b0;
            blank = 1'b0;
`ifdef DIGI_SCAN_LZB_EN
            if (sh_ben && idx != 0 && (sh_data >> (4 * idx)) == 16'h0) blank = 1'b1;
`endif
            e.seg  = {~sh_dp[idx], blank ? 7'h7F : glyph(4'(sh_data >> (4 * idx)))};
            e.fd   = (k % (D * SD) == 0);
            e.an2  = 1'b0;
            e.seg2 = {1'b1, glyph(sh2)};
            e.fd2  = (k % 2 == 0);
            if (e.fd) begin
                sh_data = data; sh_dp = dp; sh_ben = ben;
            end
            if (e.fd2) sh2 = data2;
        end
        exp_q.push_back(e);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL scoreboard_empty observed=%0d expected=1", exp_q.size());
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("an",   {4'h0, an},  {4'h0, e.an});
                chk("seg",  seg,         e.seg);
                chk("fd",   {7'h0, fd},  {7'h0, e.fd});
                chk("an2",  {7'h0, an2}, {7'h0, e.an2});
                chk("seg2", seg2,        e.seg2);
                chk("fd2",  {7'h0, fd2}, {7'h0, e.fd2});
            end
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1; data = 16'h12AF; dp = 4'h0; ben = 1'b0; bright = 2'd3;
        step(2);
        chk("reset_an",  {4'h0, an}, 8'h0F);
        chk("reset_seg", seg, 8'hFF);
        rst = 1'b0;

        step(1);
        chk("first_frame_zero", seg, 8'hC0);
        chk("single_digit_an", {7'h0, an2}, 8'h00);
        step(16);                       // edge 17: digit 0 of first snapshot
        chk("dig0_F", seg, 8'h8E);
        chk("dig0_an", {4'h0, an}, 8'h0E);
        step(4);                        // edge 21: digit 1
        chk("dig1_A", seg, 8'h88);
        chk("dig1_an", {4'h0, an}, 8'h0D);

        data = 16'h0000;                // mid-frame change must not leak
        step(11);                       // edge 32: digit 3 still old, wrap
        chk("hold_old", seg, 8'hF9);
        chk("wrap_fd", {7'h0, fd}, 8'h01);
        step(1);
        chk("new_frame", seg, 8'hC0);

        bright = 2'd1;
        step(8);
        bright = 2'd0;
        step(8);
        chk("dark_an", {4'h0, an}, 8'h0F);
        bright = 2'd3;

        data = 16'h0050; ben = 1'b1; dp = 4'h0;
        step(32);
        dp = 4'b0100;
        step(32);
        dp = 4'h0; ben = 1'b0; data = 16'h9C3E;
        step(20);

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if ((k / SD) % D == 2) found = 1'b1;
            else step(1);
        end
        n_assert++;
        assert (found) else begin
            n_fail++;
            $error("FAIL find_digit2 observed=%0d expected=1", found);
        end
        rst = 1'b1;
        step(1);
        chk("midrst_an",  {4'h0, an}, 8'h0F);
        chk("midrst_seg", seg, 8'hFF);
        rst = 1'b0;
        step(15);
        chk("post_rst_fd15", {7'h0, fd}, 8'h00);
        step(1);
        chk("post_rst_fd16", {7'h0, fd}, 8'h01);
        step(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
